// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing constants for the VGA timing generator and the
//   drawing stage. Holds the raw porch/sync figures, the derived totals, the
//   sync window bounds, the registered output bundle type and a small window
//   helper.
//   Ports: none (package).
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOT = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Inclusive sync windows in counter coordinates.
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC - 1;

  localparam int VGA_POS_W = 10;

  typedef struct packed {
    logic                 hs;
    logic                 vs;
    logic                 blank;
    logic                 line_start;
    logic                 frame_start;
    logic [VGA_POS_W-1:0] x;
    logic [VGA_POS_W-1:0] y;
  } vga_out_t;

  // Syncs idle high, everything else low while held in reset.
  localparam vga_out_t VGA_OUT_RESET = '{
    hs:          1'b1,
    vs:          1'b1,
    blank:       1'b0,
    line_start:  1'b0,
    frame_start: 1'b0,
    x:           '0,
    y:           '0
  };

  function automatic logic in_window(input logic [VGA_POS_W-1:0] pos,
                                     input logic [VGA_POS_W-1:0] lo,
                                     input logic [VGA_POS_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing. Two inline counters (hc, vc) walk the
//   full raster including blanking; every output is a registered decode of
//   the counters, so outputs lag the counters by exactly one clock and no
//   input other than reset reaches an output combinationally.
//   Ports:
//     vga_clk     in   pixel clock, rising edge
//     reset       in   asynchronous, active-high
//     hs, vs      out  horizontal / vertical sync, active-low
//     blank       out  1 = visible pixel, 0 = blanking
//     DrawX/DrawY out  position of the pixel currently shown (10 bits each)
//     line_start  out  one-cycle pulse while DrawX = 0
//     frame_start out  one-cycle pulse while DrawX = 0 and DrawY = 0
//     frame_count out  completed frames since reset, wraps at 256
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  output logic                 hs,
  output logic                 vs,
  output logic                 blank,
  output logic [VGA_POS_W-1:0] DrawX,
  output logic [VGA_POS_W-1:0] DrawY,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [7:0]           frame_count
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [VGA_POS_W-1:0] H_LAST  = VGA_POS_W'(H_TOT - 1);
  localparam logic [VGA_POS_W-1:0] V_LAST  = VGA_POS_W'(V_TOT - 1);
  localparam logic [VGA_POS_W-1:0] H_VIS   = VGA_POS_W'(H_ACTIVE);
  localparam logic [VGA_POS_W-1:0] V_VIS   = VGA_POS_W'(V_ACTIVE);
  localparam logic [VGA_POS_W-1:0] HS_LO   = VGA_POS_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_POS_W-1:0] HS_HI   = VGA_POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VGA_POS_W-1:0] VS_LO   = VGA_POS_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_POS_W-1:0] VS_HI   = VGA_POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [VGA_POS_W-1:0] hc;
  logic [VGA_POS_W-1:0] vc;
  logic                 h_wrap;
  logic                 v_wrap;
  logic [7:0]           frame_cnt;
  vga_out_t             pix_d;
  vga_out_t             pix_q;
  logic [7:0]           frame_count_q;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  // Both counters wrap on the same edge at the end of the last line, so the
  // frame boundary costs no extra cycle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      vc <= v_wrap ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // frame_cnt moves on the counter wrap; it is then re-registered alongside
  // the pixel decode so the new value shows up with the next frame_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    pix_d             = VGA_OUT_RESET;
    pix_d.hs          = ~in_window(hc, HS_LO, HS_HI);
    pix_d.vs          = ~in_window(vc, VS_LO, VS_HI);
    pix_d.blank       = (hc < H_VIS) && (vc < V_VIS);
    pix_d.line_start  = (hc == '0);
    pix_d.frame_start = (hc == '0) && (vc == '0);
    pix_d.x           = hc;
    pix_d.y           = vc;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_q         <= VGA_OUT_RESET;
      frame_count_q <= '0;
    end else begin
      pix_q         <= pix_d;
      frame_count_q <= frame_cnt;
    end
  end

  assign hs          = pix_q.hs;
  assign vs          = pix_q.vs;
  assign blank       = pix_q.blank;
  assign line_start  = pix_q.line_start;
  assign frame_start = pix_q.frame_start;
  assign DrawX       = pix_q.x;
  assign DrawY       = pix_q.y;
  assign frame_count = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, visible pixels per line; H_FP 16, horizontal front porch; H_SYNC 96, hsync width; H_BP 48, horizontal back porch; V_ACTIVE 480, visible lines; V_FP 10, vertical front porch; V_SYNC 2, vsync width; V_BP 33, vertical back porch.
REQ-002 Clocking/reset: one clock; reset is asynchronous and active-high.
REQ-003 vga_clk  in  1  pixel clock (25 MHz nominal); all state advances on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 hs  out  1  horizontal sync, active-low.
REQ-006 vs  out  1  vertical sync, active-low.
REQ-007 blank  out  1  display-enable: 1 = visible pixel (drawer outputs colour), 0 = blanking.
REQ-008 DrawX  out  10  horizontal position of the current output pixel (0..799).
REQ-009 DrawY  out  10  vertical position of the current output pixel (0..524).
REQ-010 line_start  out  1  one-cycle pulse when the outputs show DrawX = 0.
REQ-011 frame_start  out  1  one-cycle pulse when the outputs show DrawX = 0 and DrawY = 0.
REQ-012 frame_count  out  8  count of completed frames since reset, wrapping.

Function
REQ-013 Internal counters hc and vc SHALL have totals H_TOT = 800 and V_TOT = 525, each being the sum of its four parameters.
REQ-014 hc SHALL increment every cycle and wrap H_TOT-1 -> 0; vc SHALL increment only on the hc wrap and wrap V_TOT-1 -> 0 on the same edge hc wraps.
REQ-015 Outputs SHALL be registered: the values driven after edge n are the decode of the counter values held before edge n, which is a fixed 1-cycle latency.
REQ-016 DrawX SHALL equal the delayed hc and DrawY the delayed vc over the full range, blanking included.
REQ-017 blank SHALL be 1 iff delayed hc < H_ACTIVE and delayed vc < V_ACTIVE.
REQ-018 hs SHALL be 0 iff delayed hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
REQ-019 vs SHALL be 0 iff delayed vc is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491]; vs changes only with DrawX = 0.
REQ-020 line_start SHALL be 1 iff delayed hc = 0; frame_start SHALL be 1 iff delayed hc = 0 and delayed vc = 0.
REQ-021 frame_count SHALL increment on the edge where the counters wrap (799,524) -> (0,0), so its new value first appears together with the next frame_start.
REQ-022 frame_count SHALL wrap 255 -> 0 silently.
REQ-023 The first frame after reset SHALL carry frame_count = 0.
REQ-024 Simultaneous hc and vc wrap SHALL be handled in a single edge with no extra cycle and no skipped line.

Reset
REQ-025 While reset = 1: hc = 0, vc = 0, DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0, frame_count = 0, all asynchronously.
REQ-026 On the first rising edge after deassertion, outputs SHALL show pixel (0,0): blank = 1, line_start = 1, frame_start = 1, and the counters SHALL advance to (1,0).
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately, with no completion of the current line or sync pulse.

Structure
REQ-028 Timing constants, derived totals and sync-window bounds SHALL live in shared package vga_timing_pkg, which the drawing stage also imports.
REQ-029 The block SHALL be one module with no sub-modules; both counters and the output decode register are inline.
REQ-030 No combinational path SHALL exist from any input to any output except reset.

Verification
REQ-031 Release reset, run 1 cycle -> DrawX = 0, DrawY = 0, blank = 1, frame_start = 1, line_start = 1, hs = 1, vs = 1, frame_count = 0.
REQ-032 Run one full line (800 cycles) -> blank high exactly 640 cycles; hs low exactly 96 cycles starting at DrawX = 656; line_start pulses once per 800 cycles.
REQ-033 Run one full frame (420000 cycles) -> vs low for exactly 1600 cycles starting at DrawX = 0, DrawY = 490; blank high 307200 cycles total.
REQ-034 Observe the (799,524) -> (0,0) transition -> consecutive outputs (799,524) then (0,0), frame_start = 1, frame_count = 1.
REQ-035 Run 256 frames -> frame_count wraps to 0 exactly at the 256th frame_start after the first.
REQ-036 Assert reset at DrawX = 700, DrawY = 490, with hs and vs both low -> immediately hs = 1, vs = 1, blank = 0, DrawX = 0, DrawY = 0; after release, REQ-031 values repeat.
